wb_arbiter_32: RTL and testbench
================================

# wb_arbiter_32

Write-back arbiter and destination scoreboard for the 32 x 32-bit register file. It shares the register file's single synchronous write port (D, D_En, D_Addr) between two write-back requesters: port 0 carries memory loads and port 1 carries ALU results. It also tracks pending destination registers so that issue logic can detect RAW hazards. It sits between the execute/memory stages and the register file, and drives the register file's write port directly from registered outputs.

## Interface
- No parameters. Widths are fixed at 32-bit data and 5-bit register address.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 (MEM) has a write-back pending.
- req0_addr  in  5  destination register for requester 0.
- req0_data  in  32  write data for requester 0.
- req0_ready  out  1  requester 0 is granted this cycle; combinational.
- req1_valid / req1_addr / req1_data / req1_ready  same set of signals for requester 1 (ALU).
- rsv_en  in  1  issue logic reserves a destination register this cycle.
- rsv_addr  in  5  register being reserved.
- busy  out  32  scoreboard; bit n=1 means register n has a write outstanding.
- D  out  32  register file write data.
- D_En  out  1  register file write enable.
- D_Addr  out  5  register file write address.

## Operation
- Handshake: a transfer occurs on req_k when req_k_valid && req_k_ready. Requesters hold valid, addr and data stable until the transfer.
- Readiness: ready is asserted only to the granted requester, and at most one ready is high per cycle. The arbiter has no back-pressure, so a lone valid requester is always granted the same cycle.
- Arbitration: both valid -> the winner is chosen per Configuration.
- Output stage: on each edge, D/D_Addr load the granted requester's data and address.
  - D_En <= granted && addr != 0.
  - With no grant, D_En <= 0 and D/D_Addr hold their previous values.
- Register 0: a transfer to address 0 completes the handshake normally but never produces D_En=1.
- Scoreboard, evaluated per edge:
  - A transfer to register a (a != 0) clears busy[a].
  - rsv_en with rsv_addr != 0 sets busy[rsv_addr].
  - Set and clear of the same register in the same cycle -> set wins, because the new reservation supersedes the completing write.
  - busy[0] is constant 0.
- Reset: asynchronous; it clears busy, D, D_Addr and D_En, and forces the arbitration pointer to requester 0. ready outputs are 0 while reset is asserted. A transfer in flight when reset asserts is discarded.

## Timing
- Transfer at edge N -> D_En=1 with that data/address after edge N. The register file writes at edge N+1, giving a fixed 1-cycle latency.
- busy[a] clears at the same edge N as the transfer. Issue logic that reads the register at N+1 must therefore also honour the in-flight D_En/D_Addr, or stall one more cycle.
- Throughput: one write per cycle sustained.
- Reset values: D=0, D_Addr=0, D_En=0, busy=0, req0_ready=req1_ready=0 during reset.

## Configuration
- WB_RR_EN defined: round-robin arbitration using a 1-bit last-grant pointer. On conflict, the requester not granted most recently wins. The pointer updates only on a granted transfer.
- WB_RR_EN undefined: fixed priority, requester 0 (MEM) always wins on conflict. No pointer flop exists, and requester 1 can starve under continuous MEM traffic.

## Structure
- A shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - The requester index constants REQ_MEM=0 and REQ_ALU=1.
- One sub-module, wb_rr_arbiter2: a 2-input arbiter with valid inputs and one-hot grant outputs, containing the optional pointer. The top level holds the output register stage and the scoreboard.

## Test plan
- req0 only, addr=5, data=0xDEADBEEF -> req0_ready=1; next cycle D_En=1, D_Addr=5, D=0xDEADBEEF.
- Both valid for 4 cycles, addrs 3/4:
  - WB_RR_EN: D_Addr sequence 3,4,3,4.
  - Without WB_RR_EN: 3,3,3,3 with req1_ready held 0.
- req1 to addr 0, data=0x1234 -> req1_ready=1; D_En stays 0; busy unchanged.
- rsv_en addr=7 -> busy[7]=1. Later, in the same cycle, a transfer to 7 and rsv_en addr=7 -> busy[7] stays 1. A transfer alone -> busy[7]=0.
- Reset asserted mid-stream with D_En=1 -> D_En, D, D_Addr and busy drop to 0 immediately. After release with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_32_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_32_pkg
// Shared widths, requester indices and payload type for the write-back arbiter.
// Build option: WB_RR_EN selects round-robin arbitration (see wb_rr_arbiter2).
// -----------------------------------------------------------------------------
package wb_arbiter_32_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    // Requester indices into the valid/grant vectors
    localparam int unsigned REQ_MEM = 0;
    localparam int unsigned REQ_ALU = 1;

    // One write-back beat as seen by the register file
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_payload_t;

endpackage

// File: rtl/wb_arbiter_32_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_32_if
// Valid/ready write-back request channel, one instance per requester.
//   valid : requester has a write-back pending
//   addr  : destination register
//   data  : write data
//   ready : arbiter grants the requester this cycle
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface wb_arbiter_32_if;
    import wb_arbiter_32_pkg::*;

    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
    logic                  ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/wb_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter2
// Two-input arbiter with one-hot combinational grant.
//   clk, reset : clock / async active-high reset (present only with WB_RR_EN)
//   valid[1:0] : request lines, index REQ_MEM / REQ_ALU
//   grant[1:0] : one-hot grant, zero when nothing is requesting
// Build option WB_RR_EN: round-robin on conflict using a 1-bit pointer;
// otherwise fixed priority with REQ_MEM winning and no state at all.
// -----------------------------------------------------------------------------
module wb_rr_arbiter2
    import wb_arbiter_32_pkg::*;
(
`ifdef WB_RR_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef WB_RR_EN
    // Requester favoured at the next conflict
    logic prio;

    always_comb begin
        grant = valid;
        if (valid[REQ_MEM] && valid[REQ_ALU]) begin
            grant       = 2'b00;
            grant[prio] = 1'b1;
        end
    end

    // Pointer moves to the other requester after every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'(REQ_MEM);
        end else if (|grant) begin
            prio <= grant[REQ_MEM] ? 1'(REQ_ALU) : 1'(REQ_MEM);
        end
    end
`else
    always_comb begin
        grant          = 2'b00;
        grant[REQ_MEM] = valid[REQ_MEM];
        grant[REQ_ALU] = valid[REQ_ALU] & ~valid[REQ_MEM];
    end
`endif

endmodule

// File: rtl/wb_arbiter_32.sv
// -----------------------------------------------------------------------------
// wb_arbiter_32
// Write-back arbiter and destination scoreboard for the 32x32 register file.
//   clk, reset      : clock / async active-high reset
//   req0 (slave)    : MEM load write-back channel
//   req1 (slave)    : ALU result write-back channel
//   rsv_en/rsv_addr : issue logic reserves a destination register
//   busy[31:0]      : scoreboard, bit n set while register n has a write pending
//   D/D_En/D_Addr   : registered register-file write port
// Build option WB_RR_EN: round-robin arbitration instead of MEM priority.
// -----------------------------------------------------------------------------
module wb_arbiter_32
    import wb_arbiter_32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    wb_arbiter_32_if.slave        req0,
    wb_arbiter_32_if.slave        req1,
    input  logic                  rsv_en,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    output logic [NUM_REGS-1:0]   busy,
    output logic [REG_DATA_W-1:0] D,
    output logic                  D_En,
    output logic [REG_ADDR_W-1:0] D_Addr
);

    logic [1:0]          valid;
    logic [1:0]          grant;
    logic [1:0]          xfer;
    wb_payload_t         sel;
    logic [NUM_REGS-1:0] busy_next;

    assign valid = {req1.valid, req0.valid};

    wb_rr_arbiter2 u_arb (
`ifdef WB_RR_EN
        .clk   (clk),
        .reset (reset),
`endif
        .valid (valid),
        .grant (grant)
    );

    // No grant may be seen while reset is held
    assign xfer       = grant & {2{~reset}};
    assign req0.ready = xfer[REQ_MEM];
    assign req1.ready = xfer[REQ_ALU];

    // Payload of the granted requester
    always_comb begin
        sel.addr = req0.addr;
        sel.data = req0.data;
        if (xfer[REQ_ALU]) begin
            sel.addr = req1.addr;
            sel.data = req1.data;
        end
    end

    // Completing write clears, new reservation sets; set is applied last so it wins
    always_comb begin
        busy_next = busy;
        if ((|xfer) && (sel.addr != '0)) begin
            busy_next[sel.addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Register-file write stage and scoreboard state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D      <= '0;
            D_Addr <= '0;
            D_En   <= 1'b0;
            busy   <= '0;
        end else begin
            busy <= busy_next;
            if (|xfer) begin
                D      <= sel.data;
                D_Addr <= sel.addr;
                D_En   <= (sel.addr != '0);
            end else begin
                D_En   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_32.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_32
// Self-checking bench for wb_arbiter_32 with a behavioural write-back model.
// Honours WB_RR_EN in the model the same way the design does.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_32;
    import wb_arbiter_32_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy;
    logic [31:0] D;
    logic        D_En;
    logic [4:0]  D_Addr;

    wb_arbiter_32_if req0_if ();
    wb_arbiter_32_if req1_if ();

    always #5 clk = ~clk;

    wb_arbiter_32 dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0_if.slave),
        .req1     (req1_if.slave),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .D        (D),
        .D_En     (D_En),
        .D_Addr   (D_Addr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_busy;
    logic [31:0] m_d;
    logic [4:0]  m_addr;
    logic        m_en;
    int          m_last;   // index of the requester granted most recently

    task automatic model_reset();
        m_busy = '0;
        m_d    = '0;
        m_addr = '0;
        m_en   = 1'b0;
        m_last = 1;        // so that requester 0 wins the first conflict
    endtask

    // Grant expected for the inputs currently driven
    function automatic logic [1:0] model_grant();
        if (reset) return 2'b00;
        if (req0_if.valid && req1_if.valid) begin
`ifdef WB_RR_EN
            return (m_last == 0) ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return {req1_if.valid, req0_if.valid};
    endfunction

    // Advance one clock edge, updating the model with the inputs seen at it
    task automatic tick();
        logic [1:0] g;
        int         idx;
        logic [4:0] a;
        @(posedge clk);
        if (!reset) begin
            g = model_grant();
            if (g != 2'b00) begin
                idx    = g[1] ? 1 : 0;
                a      = (idx == 1) ? req1_if.addr : req0_if.addr;
                m_d    = (idx == 1) ? req1_if.data : req0_if.data;
                m_addr = a;
                m_en   = (a != 5'd0);
                if (a != 5'd0) m_busy[a] = 1'b0;
                m_last = idx;
            end else begin
                m_en = 1'b0;
            end
            if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0_if.valid = 1'b0; req0_if.addr = '0; req0_if.data = '0;
        req1_if.valid = 1'b0; req1_if.addr = '0; req1_if.data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_if.valid = 1'b1;
        req1_if.valid = 1'b1;
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL reset_d_en got=%b exp=0", D_En); end
        checks++; if (D !== 32'd0) begin errors++; $display("FAIL reset_d got=%h exp=0", D); end
        checks++; if (D_Addr !== 5'd0) begin errors++; $display("FAIL reset_d_addr got=%0d exp=0", D_Addr); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b exp=00", {req1_if.ready, req0_if.ready}); end
        tick();
        checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL reset_hold_d_en got=%b exp=0", D_En); end
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_if.valid = 1'b1; req0_if.addr = 5'd5; req0_if.data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b01) begin
            errors++; $display("FAIL single_ready got=%b exp=01", {req1_if.ready, req0_if.ready}); end
        tick();
        req0_if.valid = 1'b0;
        checks++; if (D_En !== 1'b1) begin errors++; $display("FAIL single_d_en got=%b exp=1", D_En); end
        checks++; if (D_Addr !== 5'd5) begin errors++; $display("FAIL single_d_addr got=%0d exp=5", D_Addr); end
        checks++; if (D !== 32'hDEADBEEF) begin errors++; $display("FAIL single_d got=%h exp=deadbeef", D); end
        tick();
        checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL single_idle_d_en got=%b exp=0", D_En); end
        checks++; if (D !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold_d got=%h exp=deadbeef", D); end
    endtask

    task automatic test_conflict();
        logic [4:0] exp_addr [4];
        logic       exp_r1   [4];
`ifdef WB_RR_EN
        exp_addr = '{5'd3, 5'd4, 5'd3, 5'd4};
        exp_r1   = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_addr = '{5'd3, 5'd3, 5'd3, 5'd3};
        exp_r1   = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        req0_if.valid = 1'b1; req0_if.addr = 5'd3; req0_if.data = 32'hAAAA0003;
        req1_if.valid = 1'b1; req1_if.addr = 5'd4; req1_if.data = 32'hBBBB0004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (req1_if.ready !== exp_r1[i]) begin
                errors++; $display("FAIL conflict_ready1 i=%0d got=%b exp=%b", i, req1_if.ready, exp_r1[i]); end
            checks++; if ((req0_if.ready ^ req1_if.ready) !== 1'b1) begin
                errors++; $display("FAIL conflict_onehot i=%0d got=%b%b exp=onehot", i, req1_if.ready, req0_if.ready); end
            tick();
            checks++; if (D_Addr !== exp_addr[i] || D_En !== 1'b1) begin
                errors++; $display("FAIL conflict_d_addr i=%0d got=%0d/%b exp=%0d/1", i, D_Addr, D_En, exp_addr[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_reg0();
        logic [31:0] exp_busy;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0;
        exp_busy = m_busy;
        req1_if.valid = 1'b1; req1_if.addr = 5'd0; req1_if.data = 32'h00001234;
        @(negedge clk);
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b10) begin
            errors++; $display("FAIL reg0_ready got=%b exp=10", {req1_if.ready, req0_if.ready}); end
        tick();
        req1_if.valid = 1'b0;
        checks++; if (D_En !== 1'b0) begin errors++; $display("FAIL reg0_d_en got=%b exp=0", D_En); end
        checks++; if (D !== 32'h00001234 || D_Addr !== 5'd0) begin
            errors++; $display("FAIL reg0_d got=%h@%0d exp=00001234@0", D, D_Addr); end
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL reg0_busy got=%h exp=%h", busy, exp_busy); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set got=%b exp=1", busy[7]); end
        req0_if.valid = 1'b1; req0_if.addr = 5'd7; req0_if.data = 32'h77777777;
        tick();
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", busy[7]); end
        checks++; if (D_En !== 1'b1 || D_Addr !== 5'd7) begin
            errors++; $display("FAIL sb_write got=%b@%0d exp=1@7", D_En, D_Addr); end
        rsv_en = 1'b0;
        tick();
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL sb_clear got=%b exp=0", busy[7]); end
        req0_if.valid = 1'b0;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL sb_reg0 got=%b exp=0", busy[0]); end
        checks++; if (busy !== m_busy) begin errors++; $display("FAIL sb_model got=%h exp=%h", busy, m_busy); end
    endtask

    task automatic test_random();
        logic [1:0] g;
        req0_if.valid = 1'b1; req0_if.addr = 5'($urandom_range(0, 7)); req0_if.data = $urandom;
        req1_if.valid = 1'b1; req1_if.addr = 5'($urandom_range(0, 7)); req1_if.data = $urandom;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g = model_grant();
            checks++; if ({req1_if.ready, req0_if.ready} !== g) begin
                errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {req1_if.ready, req0_if.ready}, g); end
            tick();
            checks++; if (D_En !== m_en) begin errors++; $display("FAIL rnd_d_en c=%0d got=%b exp=%b", c, D_En, m_en); end
            checks++; if (D_Addr !== m_addr) begin errors++; $display("FAIL rnd_d_addr c=%0d got=%0d exp=%0d", c, D_Addr, m_addr); end
            checks++; if (D !== m_d) begin errors++; $display("FAIL rnd_d c=%0d got=%h exp=%h", c, D, m_d); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy, m_busy); end
            // A requester holds its beat until it is granted
            if (g[0] || !req0_if.valid) begin
                req0_if.valid = ($urandom_range(0, 3) != 0);
                req0_if.addr  = 5'($urandom_range(0, 7));
                req0_if.data  = $urandom;
            end
            if (g[1] || !req1_if.valid) begin
                req1_if.valid = ($urandom_range(0, 3) != 0);
                req1_if.addr  = 5'($urandom_range(0, 7));
                req1_if.data  = $urandom;
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        req0_if.valid = 1'b1; req0_if.addr = 5'd9; req0_if.data = 32'hC0FFEE09;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        checks++; if (D_En !== 1'b1 || busy[12] !== 1'b1) begin
            errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", D_En, busy[12]); end
        rsv_en = 1'b0;
        req0_if.addr = 5'd3; req0_if.data = 32'h33333333;
        req1_if.valid = 1'b1; req1_if.addr = 5'd4; req1_if.data = 32'h44444444;
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (D_En !== 1'b0 || D !== 32'd0 || D_Addr !== 5'd0) begin
            errors++; $display("FAIL mid_outputs got=%b/%h/%0d exp=0/0/0", D_En, D, D_Addr); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL mid_busy got=%h exp=0", busy); end
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b00) begin
            errors++; $display("FAIL mid_ready got=%b exp=00", {req1_if.ready, req0_if.ready}); end
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({req1_if.ready, req0_if.ready} !== 2'b01) begin
            errors++; $display("FAIL mid_first_grant got=%b exp=01", {req1_if.ready, req0_if.ready}); end
        tick();
        checks++; if (D_Addr !== 5'd3 || D !== 32'h33333333 || D_En !== 1'b1) begin
            errors++; $display("FAIL mid_first_write got=%0d/%h/%b exp=3/33333333/1", D_Addr, D, D_En); end
        idle_inputs();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single();
        test_conflict();
        test_reg0();
        test_scoreboard();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
